// File: rtl/magcmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
//   state_e  : controller states IDLE / SCAN / HOLD
//   result_e : compare outcome EQ / LT / GT
//   clog2    : ceil(log2(n)) for sizing the digit counter
package magcmp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD
   } state_e;

   typedef enum logic [1:0] {
      RES_EQ,
      RES_LT,
      RES_GT
   } result_e;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/magcmp_digit.sv
// Combinational compare of one DIGIT-bit slice of the two operands.
// Ports:
//   a_i, b_i    : DIGIT-bit digits of operand A and B
//   dig_eq_c_o  : digits are equal
//   dig_lt_c_o  : digit of A is less than digit of B (unsigned)
module magcmp_digit
   import magcmp_pkg::*;
#(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   output logic             dig_eq_c_o,
   output logic             dig_lt_c_o
);

   assign dig_eq_c_o = (a_i == b_i);
   assign dig_lt_c_o = (a_i < b_i);

endmodule

// File: rtl/magnitude_comparator_serial.sv
// Multi-cycle magnitude comparator: compares WIDTH-bit operands MSB-first,
// DIGIT bits per clock, reporting exactly one of eq/lt/gt with valid/ready
// handshakes on both sides. Optional macro MAGCMP_EARLY_EXIT_EN ends the scan
// on the first differing digit; without it latency is always NDIG cycles.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, signed_mode    : operands and two's-complement select
//   out_valid / out_ready: result handshake
//   eq, lt, gt           : one-hot result, zero while out_valid is low
//   busy                 : controller not in IDLE
module magnitude_comparator_serial
   import magcmp_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             lt,
   output logic             gt,
   output logic             busy
);

   localparam int unsigned NDIG  = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (NDIG > 1) ? clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   if (WIDTH % DIGIT != 0) begin : g_bad_cfg
      $error("magnitude_comparator_serial: WIDTH must be a multiple of DIGIT");
   end

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [CNT_W-1:0] cnt_q;
   logic             decided_q;
   result_e          res_q;

   logic             dig_eq_c;
   logic             dig_lt_c;
   logic             done_c;
   result_e          res_c;

   magcmp_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a_i        (a_sh_q[WIDTH-1 -: DIGIT]),
      .b_i        (b_sh_q[WIDTH-1 -: DIGIT]),
      .dig_eq_c_o (dig_eq_c),
      .dig_lt_c_o (dig_lt_c)
   );

   // Result including the digit under inspection; an earlier decision wins.
   always_comb begin
      res_c = res_q;
      if (!decided_q) begin
         if (dig_eq_c) begin
            res_c = RES_EQ;
         end else if (dig_lt_c) begin
            res_c = RES_LT;
         end else begin
            res_c = RES_GT;
         end
      end
   end

   // Scan termination: last digit, or first difference when early exit is on.
`ifdef MAGCMP_EARLY_EXIT_EN
   assign done_c = (cnt_q == LAST_DIG) || !dig_eq_c;
`else
   assign done_c = (cnt_q == LAST_DIG);
`endif

   // Controller, shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         res_q     <= RES_EQ;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         gt        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Flipping both sign bits maps signed order onto unsigned order.
                  a_sh_q    <= a ^ (signed_mode ? MSB_MASK : '0);
                  b_sh_q    <= b ^ (signed_mode ? MSB_MASK : '0);
                  cnt_q     <= '0;
                  decided_q <= 1'b0;
                  res_q     <= RES_EQ;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state_q   <= SCAN;
               end
            end
            SCAN: begin
               a_sh_q    <= a_sh_q << DIGIT;
               b_sh_q    <= b_sh_q << DIGIT;
               cnt_q     <= cnt_q + CNT_W'(1);
               res_q     <= res_c;
               decided_q <= decided_q | ~dig_eq_c;
               if (done_c) begin
                  out_valid <= 1'b1;
                  eq        <= (res_c == RES_EQ);
                  lt        <= (res_c == RES_LT);
                  gt        <= (res_c == RES_GT);
                  state_q   <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  eq        <= 1'b0;
                  lt        <= 1'b0;
                  gt        <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_magnitude_comparator_serial.sv
// Directed bench for magnitude_comparator_serial: a WIDTH=16/DIGIT=4 instance
// for latency, handshake, stall and reset behaviour, and a WIDTH=16/DIGIT=16
// instance streamed with random pairs against a reference compare.
module tb_magnitude_comparator_serial;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, signed_mode, out_valid, out_ready, eq, lt, gt, busy;
   logic [15:0] a, b;
   logic        in_valid2, in_ready2, signed_mode2, out_valid2, out_ready2, eq2, lt2, gt2, busy2;
   logic [15:0] a2, b2;

   int errors = 0;
   int checks = 0;

`ifdef MAGCMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [2:0] F_EQ = 3'b100;
   localparam logic [2:0] F_LT = 3'b010;
   localparam logic [2:0] F_GT = 3'b001;

   magnitude_comparator_serial #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .eq(eq), .lt(lt), .gt(gt), .busy(busy)
   );

   magnitude_comparator_serial #(.WIDTH(16), .DIGIT(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .signed_mode(signed_mode2), .out_valid(out_valid2),
      .out_ready(out_ready2), .eq(eq2), .lt(lt2), .gt(gt2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One compare on the DIGIT=4 instance; entered and left #1 after an edge in IDLE.
   task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sm, input int lat_ee, input logic [2:0] exp_f,
                          input int stall);
      int n;
      chk({tag, ":in_ready"}, 32'(in_ready), 1);
      a = av; b = bv; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      // Operands are free to change once accepted.
      in_valid = 1'b0; a = ~av; b = 16'h0; signed_mode = ~sm;
      chk({tag, ":busy"}, 32'(busy), 1);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ":latency"}, 32'(n), 32'(EARLY ? lat_ee : 4));
      chk({tag, ":flags"}, 32'({eq, lt, gt}), 32'(exp_f));
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
         @(posedge clk); #1;
         chk({tag, ":stall_flags"}, 32'({out_valid, eq, lt, gt}), 32'({1'b1, exp_f}));
         chk({tag, ":stall_in_ready"}, 32'(in_ready), 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ":post_flags"}, 32'({out_valid, eq, lt, gt}), 0);
      chk({tag, ":post_idle"}, 32'({in_ready, busy}), 32'(2'b10));
   endtask

   initial begin
      logic [15:0] av, bv;
      logic        sm;
      logic [2:0]  ef;

      in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; signed_mode2 = 1'b0; out_ready2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset:out", 32'({out_valid, eq, lt, gt, busy}), 0);
      chk("reset:in_ready", 32'(in_ready), 1);
      chk("reset16:out", 32'({out_valid2, eq2, lt2, gt2, busy2, in_ready2}), 32'(6'b000001));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Equal operands, full scan in both builds.
      run_cmp("t1_eq",      16'h00A0, 16'h00A0, 1'b0, 4, F_EQ, 0);
      // Differ in the top digit.
      run_cmp("t2_gt",      16'h8000, 16'h7FFF, 1'b0, 1, F_GT, 0);
      // -14 vs -10: differ only in the last digit.
      run_cmp("t3_s_lt",    16'hFFF2, 16'hFFF6, 1'b1, 4, F_LT, 0);
      run_cmp("t3_u_lt",    16'hFFF2, 16'hFFF6, 1'b0, 4, F_LT, 0);
      // -2 vs 1: sign decides.
      run_cmp("t3_s_neg",   16'hFFFE, 16'h0001, 1'b1, 1, F_LT, 0);
      run_cmp("t3_u_neg",   16'hFFFE, 16'h0001, 1'b0, 1, F_GT, 0);
      // Digit 2 decides LT; digit 3 (4 > 3) must not override it.
      run_cmp("t_mid",      16'h1234, 16'h1243, 1'b0, 3, F_LT, 0);
      // Max positive vs min negative, signed.
      run_cmp("t_s_ext",    16'h7FFF, 16'h8000, 1'b1, 1, F_GT, 0);
      // Result stalled for 5 cycles with competing in_valid.
      run_cmp("t4_stall",   16'h0005, 16'h0003, 1'b0, 4, F_GT, 5);

      // Reset while SCAN is on digit 2.
      a = 16'h1234; b = 16'h1243; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("t5:scanning", 32'({busy, out_valid}), 32'(2'b10));
      rst_n = 1'b0;
      #1;
      chk("t5:async_clear", 32'({out_valid, eq, lt, gt, busy}), 0);
      chk("t5:in_ready_rst", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5:after_release", 32'({in_ready, out_valid}), 32'(2'b10));
      run_cmp("t5_next",    16'hA5A5, 16'hA5A4, 1'b0, 4, F_GT, 0);

      // DIGIT=16: back-to-back random pairs, one SCAN cycle each.
      out_ready2 = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         av = 16'($urandom);
         bv = 16'($urandom);
         if ($urandom_range(0, 7) == 0) bv = av;
         sm = 1'($urandom_range(0, 1));
         if (sm) begin
            ef = ($signed(av) < $signed(bv)) ? F_LT :
                 (($signed(av) > $signed(bv)) ? F_GT : F_EQ);
         end else begin
            ef = (av < bv) ? F_LT : ((av > bv) ? F_GT : F_EQ);
         end
         a2 = av; b2 = bv; signed_mode2 = sm; in_valid2 = 1'b1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("t6:valid", 32'(out_valid2), 1);
         chk("t6:flags", 32'({eq2, lt2, gt2}), 32'(ef));
         chk("t6:onehot", 32'($countones({eq2, lt2, gt2})), 1);
         @(posedge clk); #1;
         chk("t6:ready", 32'(in_ready2), 1);
      end
      in_valid2 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
